id_ex_pipe_reg: RTL and testbench
=================================

ID_EX_PIPE_REG -- requirements
Module: id_ex_pipe_reg

Interface
REQ-001 Parameter CTRL_W, default 8, width of control bundle (RegWrite, MemtoReg, MemWrite, MemRead, ALUSrc, RegDst, ALUOp[1:0]).
REQ-002 Parameter DATA_W, default 32, width of one data word.
REQ-003 Parameter NDATA, default 3, number of data words carried (RS data, RT data, sign-extended immediate).
REQ-004 Parameter ADDR_W, default 5, width of one register address.
REQ-005 Parameter NADDR, default 3, number of register addresses carried (RS, RT, RD).
REQ-006 clk_i  in  1  single clock, all state updates on rising edge.
REQ-007 rst_i  in  1  asynchronous, active-high reset.
REQ-008 valid_i  in  1  upstream (ID) has a valid instruction.
REQ-009 ready_o  out  1  stage can accept; a transfer occurs when valid_i && ready_o.
REQ-010 ctrl_i / ctrl_o  in / out  CTRL_W  control bundle.
REQ-011 data_i / data_o  in / out  NDATA*DATA_W  packed data words, word k at bits [k*DATA_W +: DATA_W].
REQ-012 addr_i / addr_o  in / out  NADDR*ADDR_W  packed register addresses, same packing rule.
REQ-013 flush_i  in  1  kill stage contents (branch/hazard bubble).
REQ-014 valid_o  out  1  stage holds a valid instruction for EX.
REQ-015 ready_i  in  1  downstream (EX) accepts; transfer when valid_o && ready_i.
REQ-016 stall_clr_i  in  1  synchronous clear of stall counter.
REQ-017 stall_cnt_o  out  16  saturating count of downstream-stall cycles.

Function
REQ-018 All outputs except ready_o shall be driven directly from registers; no combinational path from any *_i to ctrl_o/data_o/addr_o/valid_o.
REQ-019 Latency shall be exactly one cycle: an input accepted at edge N appears on outputs after edge N when the stage was empty or draining.
REQ-020 Main register shall load input when valid_i && ready_o and (!valid_o || ready_i); it shall hold all outputs stable while valid_o && !ready_i.
REQ-021 When downstream drains (valid_o && ready_i) with no new input, valid_o shall go 0 next cycle; ctrl_o shall become all-zero; data_o/addr_o may hold.
REQ-022 Whenever valid_o = 0, ctrl_o shall be all-zero (bubble: no register write, no memory access).
REQ-023 flush_i shall take priority over every load: next cycle valid_o = 0, ctrl_o = 0, skid entry (if present) emptied, and any input accepted that same cycle discarded.
REQ-024 ready_o shall be unaffected by flush_i in the cycle it is asserted.
REQ-025 stall_cnt_o shall increment by 1 each cycle valid_o && !ready_i, saturate at 16'hFFFF, and clear to 0 when stall_clr_i = 1; clear wins over simultaneous increment.
REQ-026 Data ordering shall be preserved; no instruction shall be duplicated or lost except by flush.

Reset
REQ-027 While rst_i = 1, asynchronously: valid_o = 0, ctrl_o = 0, data_o = 0, addr_o = 0, stall_cnt_o = 0, skid empty.
REQ-028 ready_o shall be 1 during and immediately after reset; reset asserted mid-stall shall discard both held entries.

Configuration
REQ-029 Macro ID_EX_SKID_EN: when undefined, ready_o = !valid_o || ready_i (combinational), capacity 1.
REQ-030 When ID_EX_SKID_EN is defined, a one-entry skid buffer is added: ready_o = !skid_valid (registered); an input accepted while valid_o && !ready_i goes to skid; on the next drain the main register loads from skid before any new input; capacity 2.
REQ-031 Both configurations shall present identical output sequences for identical accepted-input sequences.

Verification
REQ-032 Reset: assert rst_i mid-cycle with valid_o=1 -> valid_o, ctrl_o, data_o, addr_o, stall_cnt_o all 0 immediately; ready_o=1.
REQ-033 Streaming: ready_i=1, 4 back-to-back inputs ctrl=8'hA5 data word0=32'h1..4 -> valid_o=1 one cycle later, outputs in order, one per cycle.
REQ-034 Stall: load data word0=32'hDEADBEEF, hold ready_i=0 for 5 cycles -> outputs stable, stall_cnt_o=5; no-skid ready_o=0; skid build accepts one more entry then ready_o=0.
REQ-035 Flush: valid_o=1, flush_i=1 together with valid_i=1 -> next cycle valid_o=0, ctrl_o=8'h00, accepted input never appears.
REQ-036 Saturation: preload stall_cnt_o to 16'hFFFE, stall 3 cycles -> stays 16'hFFFF; stall_clr_i with stall -> 0.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ============================================================================
// Module      : id_ex_pipe_reg
// Description : ID->EX pipeline register with valid/ready handshake, flush,
//               bubble insertion and a saturating downstream-stall counter.
//               Define ID_EX_SKID_EN to add a one-entry skid buffer so that
//               ready_o is taken straight from a flop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_pipe_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 32,
    parameter int NDATA  = 3,
    parameter int ADDR_W = 5,
    parameter int NADDR  = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [CTRL_W-1:0]        ctrl_i,
    input  logic [NDATA*DATA_W-1:0]  data_i,
    input  logic [NADDR*ADDR_W-1:0]  addr_i,
    input  logic                     flush_i,
    output logic                     valid_o,
    output logic [CTRL_W-1:0]        ctrl_o,
    output logic [NDATA*DATA_W-1:0]  data_o,
    output logic [NADDR*ADDR_W-1:0]  addr_o,
    input  logic                     ready_i,
    input  logic                     stall_clr_i,
    output logic [15:0]              stall_cnt_o
);

    localparam int          DW       = NDATA * DATA_W;
    localparam int          AW       = NADDR * ADDR_W;
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DW-1:0]     main_data;
    logic [AW-1:0]     main_addr;
    logic [15:0]       stall_cnt;

    logic accept;
    logic drain;
    logic stalled;

    assign stalled = main_valid && !ready_i;
    assign drain   = !main_valid || ready_i;
    assign accept  = valid_i && ready_o;

    assign valid_o     = main_valid;
    assign ctrl_o      = main_ctrl;
    assign data_o      = main_data;
    assign addr_o      = main_addr;
    assign stall_cnt_o = stall_cnt;

`ifdef ID_EX_SKID_EN
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DW-1:0]     skid_data;
    logic [AW-1:0]     skid_addr;

    // ready_o is low whenever the skid holds an entry, so accept and a
    // skid-to-main transfer never coincide.
    assign ready_o = !skid_valid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
            main_addr  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
            skid_addr  <= '0;
        end else if (flush_i) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
        end else if (drain) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_ctrl  <= skid_ctrl;
                main_data  <= skid_data;
                main_addr  <= skid_addr;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_valid <= 1'b1;
                main_ctrl  <= ctrl_i;
                main_data  <= data_i;
                main_addr  <= addr_i;
            end else begin
                main_valid <= 1'b0;
                main_ctrl  <= '0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_ctrl  <= ctrl_i;
            skid_data  <= data_i;
            skid_addr  <= addr_i;
        end
    end
`else
    assign ready_o = drain;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
            main_addr  <= '0;
        end else if (flush_i) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
        end else if (accept) begin
            main_valid <= 1'b1;
            main_ctrl  <= ctrl_i;
            main_data  <= data_i;
            main_addr  <= addr_i;
        end else if (drain) begin
            // Bubble: data/addr are left as-is, only control is zeroed.
            main_valid <= 1'b0;
            main_ctrl  <= '0;
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (stall_clr_i) begin
            stall_cnt <= '0;
        end else if (stalled && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipe_reg.sv
// ============================================================================
// Module      : tb_id_ex_pipe_reg
// Description : Directed self-checking bench for id_ex_pipe_reg (both builds).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_pipe_reg;

    localparam int CTRL_W = 8;
    localparam int DATA_W = 32;
    localparam int NDATA  = 3;
    localparam int ADDR_W = 5;
    localparam int NADDR  = 3;
    localparam int DW     = NDATA * DATA_W;
    localparam int AW     = NADDR * ADDR_W;

    logic              clk;
    logic              rst;
    logic              valid_i;
    logic              ready_o;
    logic [CTRL_W-1:0] ctrl_i;
    logic [DW-1:0]     data_i;
    logic [AW-1:0]     addr_i;
    logic              flush_i;
    logic              valid_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic [DW-1:0]     data_o;
    logic [AW-1:0]     addr_o;
    logic              ready_i;
    logic              stall_clr_i;
    logic [15:0]       stall_cnt_o;

    int checks = 0;
    int errors = 0;

    id_ex_pipe_reg #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NDATA(NDATA),
        .ADDR_W(ADDR_W), .NADDR(NADDR)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .ctrl_i      (ctrl_i),
        .data_i      (data_i),
        .addr_i      (addr_i),
        .flush_i     (flush_i),
        .valid_o     (valid_o),
        .ctrl_o      (ctrl_o),
        .data_o      (data_o),
        .addr_o      (addr_o),
        .ready_i     (ready_i),
        .stall_clr_i (stall_clr_i),
        .stall_cnt_o (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Word packing used for every vector: {~w0, w0 + 0x10, w0}
    function automatic logic [DW-1:0] pack(input logic [31:0] w0);
        return {~w0, w0 + 32'h10, w0};
    endfunction

    function automatic logic [AW-1:0] apack(input logic [4:0] a);
        return {a ^ 5'h1F, a + 5'd1, a};
    endfunction

    task automatic drive(input logic v, input logic [7:0] c, input logic [31:0] w0, input logic [4:0] a);
        valid_i = v;
        ctrl_i  = c;
        data_i  = pack(w0);
        addr_i  = apack(a);
    endtask

    initial begin
        rst = 1'b1;
        valid_i = 1'b0; ctrl_i = '0; data_i = '0; addr_i = '0;
        flush_i = 1'b0; ready_i = 1'b0; stall_clr_i = 1'b0;

        // Reset state
        #3;
        check("rst_valid", valid_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_cnt", stall_cnt_o, 0);
        check("rst_ctrl", ctrl_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check("post_rst_ready", ready_o, 1);

        // Streaming: 4 back-to-back with ready_i=1
        ready_i = 1'b1;
        drive(1'b1, 8'hA5, 32'h1, 5'd1);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            check("stream_valid", valid_o, 1);
            check("stream_ctrl", ctrl_o, 8'hA5);
            check("stream_data", data_o, pack(32'(k - 1)));
            check("stream_addr", addr_o, apack(5'(k - 1)));
            if (k <= 4) drive(1'b1, 8'hA5, 32'(k), 5'(k));
            else        valid_i = 1'b0;
        end
        @(negedge clk);
        check("drain_valid", valid_o, 0);
        check("drain_ctrl", ctrl_o, 0);
        check("stream_cnt", stall_cnt_o, 0);

        // Stall: load DEADBEEF, hold ready_i=0 for 5 cycles, second entry waiting
        drive(1'b1, 8'h3C, 32'hDEADBEEF, 5'd7);
        ready_i = 1'b0;
        @(negedge clk);
        drive(1'b1, 8'h81, 32'h2222, 5'd9);
        #1;
`ifdef ID_EX_SKID_EN
        check("skid_ready_open", ready_o, 1);
        @(negedge clk);
        valid_i = 1'b0;
        #1 check("skid_ready_full", ready_o, 0);
        repeat (4) @(negedge clk);
`else
        check("stall_ready", ready_o, 0);
        repeat (5) @(negedge clk);
`endif
        check("stall_valid", valid_o, 1);
        check("stall_ctrl", ctrl_o, 8'h3C);
        check("stall_data", data_o, pack(32'hDEADBEEF));
        check("stall_cnt5", stall_cnt_o, 5);
        check("stall_ready_end", ready_o, 0);
        ready_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        check("second_valid", valid_o, 1);
        check("second_ctrl", ctrl_o, 8'h81);
        check("second_data", data_o, pack(32'h2222));
        check("cnt_hold", stall_cnt_o, 5);
        @(negedge clk);
        check("after_stall_valid", valid_o, 0);
        check("after_stall_ctrl", ctrl_o, 0);

        // Flush with simultaneous accepted input
        drive(1'b1, 8'h5A, 32'h33, 5'd3);
        @(negedge clk);
        check("pre_flush_data", data_o, pack(32'h33));
        drive(1'b1, 8'h77, 32'h44, 5'd4);
        flush_i = 1'b1;
        #1 check("flush_ready", ready_o, 1);
        @(negedge clk);
        flush_i = 1'b0;
        valid_i = 1'b0;
        check("flush_valid", valid_o, 0);
        check("flush_ctrl", ctrl_o, 0);
        @(negedge clk);
        check("flush_no_ghost", valid_o, 0);

        // Flush during a stall with a skid/waiting entry
        drive(1'b1, 8'h11, 32'h66, 5'd6);
        ready_i = 1'b0;
        @(negedge clk);
        drive(1'b1, 8'h12, 32'h67, 5'd6);
        @(negedge clk);
        valid_i = 1'b0;
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        ready_i = 1'b1;
        check("stall_flush_valid", valid_o, 0);
        @(negedge clk);
        check("stall_flush_empty", valid_o, 0);
        check("stall_flush_ctrl", ctrl_o, 0);

        // Reset asserted mid-stall
        stall_clr_i = 1'b1;
        drive(1'b1, 8'h99, 32'h55, 5'd5);
        ready_i = 1'b0;
        @(negedge clk);
        stall_clr_i = 1'b0;
        drive(1'b1, 8'h98, 32'h56, 5'd5);
        @(negedge clk);
        valid_i = 1'b0;
        check("pre_rst_valid", valid_o, 1);
        check("pre_rst_cnt", stall_cnt_o, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", valid_o, 0);
        check("async_rst_ctrl", ctrl_o, 0);
        check("async_rst_data", data_o, 0);
        check("async_rst_addr", addr_o, 0);
        check("async_rst_cnt", stall_cnt_o, 0);
        check("async_rst_ready", ready_o, 1);
        @(negedge clk);
        rst = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        check("rst_discard", valid_o, 0);

        // Saturation
        stall_clr_i = 1'b1;
        drive(1'b1, 8'hC3, 32'h7, 5'd2);
        @(negedge clk);
        stall_clr_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        repeat (65534) @(negedge clk);
        check("sat_fffe", stall_cnt_o, 16'hFFFE);
        repeat (3) @(negedge clk);
        check("sat_ffff", stall_cnt_o, 16'hFFFF);
        check("sat_data_hold", data_o, pack(32'h7));
        stall_clr_i = 1'b1;
        @(negedge clk);
        stall_clr_i = 1'b0;
        check("clr_wins", stall_cnt_o, 0);
        ready_i = 1'b1;
        @(negedge clk);
        check("final_drain", valid_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
